// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipe: forwarding selects, load-use stall, branch flush, memory hold.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
   parameter int REG_ADDR_W   = 5,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic                  id_rs1_used,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_we,
   input  logic                  id_is_load,
   input  logic                  ex_branch_taken,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  stall_if,
   output logic                  stall_id,
   output logic                  bubble_ex,
   output logic                  flush_if_id,
   output logic                  pipe_hold,
   output logic [1:0]            fwd_rs1_sel,
   output logic [1:0]            fwd_rs2_sel,
   output logic [1:0]            ctrl_state
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]           perf_stall_cnt,
   output logic [31:0]           perf_flush_cnt,
   output logic [31:0]           perf_hold_cnt
`endif
);

   typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2} state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   state_t                  state_reg, state_next, ret_reg, ret_next, eff_state;
   logic [2:0]              cnt_reg, cnt_next;
   logic                    hold, flush, load_use, enter;
   logic [1:0]              sel1_next, sel2_next, sel1_reg, sel2_reg;

   // WB is not tracked: the register file is write-through.
   logic                    ex_we_reg, ex_load_reg, mem_we_reg;
   logic [REG_ADDR_W-1:0]   ex_rd_reg, mem_rd_reg;

   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs, input logic used,
                                          input logic ex_we, input logic [REG_ADDR_W-1:0] ex_rd,
                                          input logic mem_we, input logic [REG_ADDR_W-1:0] mem_rd);
      logic [1:0] s;
      s = 2'd0;
      if (used && rs != '0) begin
         if (ex_we && ex_rd == rs)        s = 2'd1;
         else if (mem_we && mem_rd == rs) s = 2'd2;
      end
      return s;
   endfunction

   always_comb begin
      hold       = rst_n & mem_req & ~mem_ready;
      eff_state  = (state_reg == MEM_WAIT) ? ret_reg : state_reg;
      flush      = 1'b0;
      load_use   = 1'b0;
      state_next = state_reg;
      ret_next   = ret_reg;
      cnt_next   = cnt_reg;
      if (hold) begin
         state_next = MEM_WAIT;
         if (state_reg != MEM_WAIT) ret_next = state_reg;
      end else if (rst_n) begin
         case (eff_state)
            FLUSH: begin
               flush      = 1'b1;
               cnt_next   = cnt_reg - 3'd1;
               state_next = (cnt_reg == 3'd1) ? RUN : FLUSH;
            end
            default: begin
               state_next = RUN;
               if (ex_branch_taken) begin
                  flush = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_next = FLUSH;
                     cnt_next   = FLUSH_INIT;
                  end
               end else if (id_valid && ex_load_reg && ex_we_reg && ex_rd_reg != '0 &&
                            ((id_rs1_used && id_rs1 == ex_rd_reg) ||
                             (id_rs2_used && id_rs2 == ex_rd_reg))) begin
                  load_use = 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      enter     = id_valid & ~load_use & ~flush;
      sel1_next = 2'd0;
      sel2_next = 2'd0;
      if (enter) begin
         sel1_next = fwd_sel(id_rs1, id_rs1_used, ex_we_reg, ex_rd_reg, mem_we_reg, mem_rd_reg);
         sel2_next = fwd_sel(id_rs2, id_rs2_used, ex_we_reg, ex_rd_reg, mem_we_reg, mem_rd_reg);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= RUN;
         ret_reg     <= RUN;
         cnt_reg     <= 3'd0;
         ex_we_reg   <= 1'b0;
         ex_load_reg <= 1'b0;
         ex_rd_reg   <= '0;
         mem_we_reg  <= 1'b0;
         mem_rd_reg  <= '0;
         sel1_reg    <= 2'd0;
         sel2_reg    <= 2'd0;
      end else begin
         state_reg <= state_next;
         ret_reg   <= ret_next;
         cnt_reg   <= cnt_next;
         if (!hold) begin
            mem_we_reg  <= ex_we_reg;
            mem_rd_reg  <= ex_rd_reg;
            ex_we_reg   <= enter & id_reg_we;
            ex_load_reg <= enter & id_is_load;
            ex_rd_reg   <= enter ? id_rd : '0;
            sel1_reg    <= sel1_next;
            sel2_reg    <= sel2_next;
         end
      end
   end

   assign stall_if    = load_use;
   assign stall_id    = load_use;
   assign bubble_ex   = load_use;
   assign flush_if_id = flush;
   assign pipe_hold   = hold;
   assign fwd_rs1_sel = sel1_reg;
   assign fwd_rs2_sel = sel2_reg;
   assign ctrl_state  = state_reg;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_reg, flush_cnt_reg, hold_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= 32'd0;
         flush_cnt_reg <= 32'd0;
         hold_cnt_reg  <= 32'd0;
      end else begin
         stall_cnt_reg <= stall_cnt_reg + 32'(load_use);
         flush_cnt_reg <= flush_cnt_reg + 32'(flush);
         hold_cnt_reg  <= hold_cnt_reg + 32'(hold);
      end
   end

   assign perf_stall_cnt = stall_cnt_reg;
   assign perf_flush_cnt = flush_cnt_reg;
   assign perf_hold_cnt  = hold_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: an instruction-level pipeline model pushes expected
// per-cycle outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl;
   localparam int W  = 5;
   localparam int FC = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         id_valid = 0, id_rs1_used = 0, id_rs2_used = 0, id_reg_we = 0, id_is_load = 0;
   logic [W-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic         ex_branch_taken = 0, mem_req = 0, mem_ready = 0;
   logic         stall_if, stall_id, bubble_ex, flush_if_id, pipe_hold;
   logic [1:0]   fwd_rs1_sel, fwd_rs2_sel, ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0]  perf_stall_cnt, perf_flush_cnt, perf_hold_cnt;
`endif

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_ADDR_W(W), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
      .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_reg_we(id_reg_we), .id_is_load(id_is_load),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
      .flush_if_id(flush_if_id), .pipe_hold(pipe_hold),
      .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .ctrl_state(ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_hold_cnt(perf_hold_cnt)
`endif
   );

   typedef struct packed {
      logic        si, sd, bx, fl, ph;
      logic [1:0]  f1, f2, st;
      logic [31:0] pc_s, pc_f, pc_h;
   } exp_t;

   typedef struct {
      bit           we;
      logic [W-1:0] rd;
      bit           load;
   } ins_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: instructions in EX and MEM, remaining flush slots, hold history.
   ins_t        m_ex, m_mem;
   int          flush_left;
   bit          prev_held;
   logic [1:0]  m_f1, m_f2;
   logic [31:0] cnt_s, cnt_f, cnt_h;

   function automatic logic [1:0] fwd(input logic [W-1:0] rs, input bit used);
      if (!used || rs == '0) return 2'd0;
      if (m_ex.we && m_ex.rd == rs) return 2'd1;
      if (m_mem.we && m_mem.rd == rs) return 2'd2;
      return 2'd0;
   endfunction

   task automatic model_reset();
      m_ex = '{0, '0, 0};
      m_mem = '{0, '0, 0};
      flush_left = 0;
      prev_held = 0;
      m_f1 = 2'd0;
      m_f2 = 2'd0;
      cnt_s = 0; cnt_f = 0; cnt_h = 0;
   endtask

   task automatic step();
      exp_t e;
      bit   held, br, fl, lu;
      ins_t nxt;
      e = '0;
      if (!rst_n) begin
         model_reset();
         q.push_back(e);
         return;
      end
      held = mem_req && !mem_ready;
      e.st = prev_held ? 2'd2 : (flush_left > 0 ? 2'd1 : 2'd0);
      e.f1 = m_f1;
      e.f2 = m_f2;
      e.pc_s = cnt_s; e.pc_f = cnt_f; e.pc_h = cnt_h;
      if (held) begin
         e.ph = 1'b1;
         prev_held = 1;
         cnt_h = cnt_h + 1;
      end else begin
         br = (flush_left == 0) && ex_branch_taken;
         fl = br || (flush_left > 0);
         lu = !fl && id_valid && m_ex.load && m_ex.we && m_ex.rd != '0 &&
              ((id_rs1_used && id_rs1 == m_ex.rd) || (id_rs2_used && id_rs2 == m_ex.rd));
         e.fl = fl; e.si = lu; e.sd = lu; e.bx = lu;
         if (id_valid && !fl && !lu) begin
            nxt = '{id_reg_we, id_rd, id_is_load};
            m_f1 = fwd(id_rs1, id_rs1_used);
            m_f2 = fwd(id_rs2, id_rs2_used);
         end else begin
            nxt = '{0, '0, 0};
            m_f1 = 2'd0;
            m_f2 = 2'd0;
         end
         m_mem = m_ex;
         m_ex = nxt;
         if (br) flush_left = FC - 1;
         else if (flush_left > 0) flush_left = flush_left - 1;
         prev_held = 0;
         if (lu) cnt_s = cnt_s + 1;
         if (fl) cnt_f = cnt_f + 1;
      end
      q.push_back(e);
   endtask

   task automatic drive(input bit v, input logic [W-1:0] r1, input bit u1,
                        input logic [W-1:0] r2, input bit u2, input logic [W-1:0] rd,
                        input bit we, input bit ld, input bit br, input bit mq, input bit mr);
      @(posedge clk); #1;
      rst_n = 1'b1;
      id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
      id_rd = rd; id_reg_we = we; id_is_load = ld;
      ex_branch_taken = br; mem_req = mq; mem_ready = mr;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rst_pulse();
      @(posedge clk); #1;
      rst_n = 1'b0;
      ex_branch_taken = 1'b1;
      id_valid = 1'b1;
      step();
   endtask

   exp_t mon_e, mon_a;
   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         mon_a = '0;
         mon_a.si = stall_if; mon_a.sd = stall_id; mon_a.bx = bubble_ex;
         mon_a.fl = flush_if_id; mon_a.ph = pipe_hold;
         mon_a.f1 = fwd_rs1_sel; mon_a.f2 = fwd_rs2_sel; mon_a.st = ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
         mon_a.pc_s = perf_stall_cnt; mon_a.pc_f = perf_flush_cnt; mon_a.pc_h = perf_hold_cnt;
`else
         mon_e.pc_s = 0; mon_e.pc_f = 0; mon_e.pc_h = 0;
`endif
         vectors++;
         if (mon_a !== mon_e) begin
            miscompares++;
            $display("FAIL vec %0d: got stall=%b%b%b flush=%b hold=%b sel=%0d/%0d st=%0d perf=%0d/%0d/%0d, want stall=%b%b%b flush=%b hold=%b sel=%0d/%0d st=%0d perf=%0d/%0d/%0d",
                     vectors, mon_a.si, mon_a.sd, mon_a.bx, mon_a.fl, mon_a.ph, mon_a.f1, mon_a.f2, mon_a.st,
                     mon_a.pc_s, mon_a.pc_f, mon_a.pc_h,
                     mon_e.si, mon_e.sd, mon_e.bx, mon_e.fl, mon_e.ph, mon_e.f1, mon_e.f2, mon_e.st,
                     mon_e.pc_s, mon_e.pc_f, mon_e.pc_h);
         end else begin
            $display("vec %0d ok: stall=%b flush=%b hold=%b sel=%0d/%0d st=%0d",
                     vectors, mon_a.si, mon_a.fl, mon_a.ph, mon_a.f1, mon_a.f2, mon_a.st);
         end
      end
   end

   initial begin
      model_reset();
      idle(3);
      // addi x5,x0 ; add x6,x5,x5 ; add x7,x5,x0 ; then drain
      drive(1, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
      drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0);
      drive(1, 5, 1, 0, 1, 7, 1, 0, 0, 0, 0);
      idle(3);
      // lw x3 ; add x4,x3,x1 (stalled, then re-presented)
      drive(1, 2, 1, 0, 0, 3, 1, 1, 0, 0, 0);
      drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0);
      drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0);
      idle(3);
      // taken branch, three flush cycles
      drive(1, 1, 1, 2, 1, 8, 1, 0, 1, 0, 0);
      drive(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 0);
      drive(1, 8, 1, 0, 0, 9, 1, 0, 1, 0, 0);
      drive(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 0);
      idle(2);
      // memory wait of four cycles with a pending forward in flight
      drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0);
      drive(1, 10, 1, 10, 1, 11, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 10, 1, 11, 1, 12, 1, 0, 0, 1, 0);
      drive(1, 10, 1, 11, 1, 12, 1, 0, 0, 1, 1);
      idle(2);
      // branch under hold, then hold in the middle of the flush
      drive(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
      // x0 written then read: never forwarded
      drive(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0);
      drive(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0);
      idle(2);
      // reset pulsed during flush
      drive(1, 1, 1, 1, 1, 2, 1, 0, 1, 0, 0);
      drive(1, 2, 1, 2, 1, 3, 1, 0, 0, 0, 0);
      rst_pulse();
      idle(3);
      // randomized traffic over a small register window to provoke hazards
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 3) != 0,
               W'($urandom_range(0, 3)), 1'($urandom), W'($urandom_range(0, 3)), 1'($urandom),
               W'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 2) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);
         if (i == 150) rst_pulse();
      end
      idle(4);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB), added alongside the existing stage modules. It keeps a shadow scoreboard of destination registers in EX/MEM/WB and produces registered forwarding selects for the EX operands. It generates load-use stalls, a multi-cycle wrong-path flush after taken branches/jumps, and a whole-pipe hold while data memory is not ready.

Parameters:
REG_ADDR_W, 5, register index width (log2 of register count).
FLUSH_CYCLES, 1, cycles flush_if_id stays asserted after a taken branch (1..4; sized for ROM latency).

Ports:
clk  in  1  clock (rising edge)
rst_n  in  1  reset; asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_ADDR_W  ID source 1 index
id_rs1_used  in  1  ID reads rs1
id_rs2  in  REG_ADDR_W  ID source 2 index
id_rs2_used  in  1  ID reads rs2
id_rd  in  REG_ADDR_W  ID destination index
id_reg_we  in  1  ID writes rd
id_is_load  in  1  ID is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
mem_req  in  1  MEM stage holds a load/store
mem_ready  in  1  data memory completes this cycle
stall_if  out  1  hold PC and IF/ID register
stall_id  out  1  hold ID/EX inputs (ID instruction re-presented)
bubble_ex  out  1  load ID/EX register with a NOP
flush_if_id  out  1  kill IF and ID contents
pipe_hold  out  1  freeze every pipeline register
fwd_rs1_sel  out  2  EX operand 1 source: 0 regfile, 1 MEM result, 2 WB data
fwd_rs2_sel  out  2  EX operand 2 source, same encoding
ctrl_state  out  2  FSM state, debug

Behaviour:
- States: RUN=0, FLUSH=1, MEM_WAIT=2. Reset: RUN, flush counter 0, all shadow entries we=0/rd=0/load=0, fwd selects 0.
- Outputs stall_if, stall_id, bubble_ex, flush_if_id, pipe_hold are combinational from state and inputs; all are 0 while rst_n low.
- Priority per cycle: pipe_hold > flush > load-use stall.
- pipe_hold = mem_req & ~mem_ready. Any state enters MEM_WAIT while it holds. In MEM_WAIT nothing advances: shadow regs, fwd selects and flush counter all frozen. ex_branch_taken is ignored during hold; EX is frozen, so it is re-presented after release.
- Exit MEM_WAIT the cycle mem_ready=1. Return to the state saved on entry; FLUSH resumes its remaining count.
- Taken branch, not held: flush_if_id=1 that cycle; EX-entry slot gets a bubble.
  - If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; flush_if_id stays 1 while counter>0, decrementing each unheld cycle; return to RUN at 0.
  - A new ex_branch_taken in FLUSH cannot occur (EX holds bubbles); ignore it.
- Load-use: RUN, no flush, no hold, id_valid, shadow EX entry load=1, we=1, rd!=0, and rd matches a used ID source → stall_if=stall_id=bubble_ex=1 for exactly one cycle. The next cycle the load is in MEM; its result is taken from WB.
- Shadow advance every unheld cycle:
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields if id_valid and no bubble/flush; otherwise zeros.
- Forwarding select, registered on the same advance:
  - For each used, nonzero source, compare against the current EX shadow (becomes MEM → sel 1), then the current MEM shadow (becomes WB → sel 2). Youngest wins.
  - Otherwise sel 0. Select is 0 when the entry carries a bubble.
  - Register file is write-through, so the current WB needs no bypass.
- x0 is never a hazard and is never forwarded.
- Reset mid-operation clears state, counter and shadow immediately (async).

Optional Feature:
HAZARD_PERF_CNT_EN: when defined, adds outputs perf_stall_cnt[31:0], perf_flush_cnt[31:0], perf_hold_cnt[31:0].
- stall counts load-use cycles; flush counts cycles with flush_if_id=1; hold counts pipe_hold cycles.
- Counters wrap at 2^32 and reset to 0.
When undefined, these ports and their logic are absent; other behaviour is identical.

Test Plan:
- Back-to-back dependency: addi x5; add x6,x5,x5 issued consecutively → second instruction's fwd_rs1_sel=fwd_rs2_sel=1 in EX; add x7,x5 two later → sel 2.
- Load-use: lw x3 then add x4,x3,x1 → exactly one cycle stall_if=stall_id=bubble_ex=1, then fwd_rs1_sel=2, fwd_rs2_sel=0.
- Taken branch with FLUSH_CYCLES=3 → flush_if_id high 3 consecutive cycles, ctrl_state 0→1→1→0, no stall.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles → pipe_hold=1 for 4 cycles, ctrl_state=2, fwd selects unchanged; release on mem_ready=1.
- Branch taken in same cycle as hold, then FLUSH held mid-count → flush deferred until release; remaining count preserved; writes to x0 never produce sel≠0.
- rst_n pulsed low during FLUSH → ctrl_state=0, all outputs 0 asynchronously; with HAZARD_PERF_CNT_EN, counters read 0.
